hazard_fwd_ctrl: RTL and testbench

Pipeline hazard and forwarding controller for the five-stage core. It tracks the destination register of every instruction in EX, M and WB using its own shadow pipeline. When an instruction issues from ID, it computes the `forward_1`/`forward_2` select codes consumed by the rs1/rs2 operand muxes in EX. It also raises the load-use stall and bubble-insert signals for IF/ID/EX.

---
 rtl/hazard_fwd_ctrl_pkg.sv | 29 ++
 rtl/hazard_src_cmp.sv | 36 +++
 rtl/hazard_fwd_ctrl.sv | 112 +++++++++++
 tb/tb_hazard_fwd_ctrl.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/hazard_fwd_ctrl_pkg.sv
// Shared widths, forward select codes and the shadow-pipeline entry type for the hazard/forwarding controller.
// No logic, so no latency and no backpressure.
// The rd/we/is_load fields mirror what ID hands to EX.
package hazard_fwd_ctrl_pkg;

    localparam int CPU_WIDTH          = 32;
    localparam int REG_ADDR_WIDTH     = 5;
    localparam int FORWARD_CTRL_WIDTH = 2;

    typedef logic [FORWARD_CTRL_WIDTH-1:0] fwd_t;
    typedef logic [REG_ADDR_WIDTH-1:0]     reg_idx_t;

    localparam fwd_t FWD_NONE = 2'b00;
    localparam fwd_t FWD_M    = 2'b10;
    localparam fwd_t FWD_WB   = 2'b01;

    typedef struct packed {
        logic     valid;
        reg_idx_t rd;
        logic     we;
        logic     is_load;
    } shadow_t;

    // x0 is hardwired to zero, so it never creates a dependency.
    function automatic logic src_match(input shadow_t ent, input reg_idx_t src, input logic used);
        return ent.valid && ent.we && (ent.rd == src) && (src != '0) && used;
    endfunction

endpackage

// File: rtl/hazard_src_cmp.sv
// Compares one ID source register against the EX and M shadow entries; youngest producer wins.
// Purely combinational, zero latency.
// No backpressure; results feed the stall and forward-select logic of the top.
module hazard_src_cmp
    import hazard_fwd_ctrl_pkg::*;
(
    input  reg_idx_t src,
    input  logic     src_used,
    input  shadow_t  ex_ent,
    input  shadow_t  m_ent,
    output fwd_t     fwd_code,
    output logic     load_hit,
    output logic     raw_hit
);

    logic ex_hit;
    logic m_hit;
    logic unused_ok;

    always_comb begin
        ex_hit   = src_match(ex_ent, src, src_used);
        m_hit    = src_match(m_ent, src, src_used);
        fwd_code = FWD_NONE;
        if (ex_hit) begin
            fwd_code = FWD_M;
        end else if (m_hit) begin
            fwd_code = FWD_WB;
        end
        load_hit = ex_hit && ex_ent.is_load;
        raw_hit  = ex_hit || m_hit;
    end

    // A load already in M resolves by forwarding, so its load flag is irrelevant here.
    assign unused_ok = m_ent.is_load;

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// Hazard/forwarding controller: shadow EX/M/WB pipeline, registered rs1/rs2 forward selects, load-use stall.
// Forward selects and bubble_ex are registered (valid while the consumer is in EX); stall is combinational.
// Stall holds PC and IF/ID; FORWARDING_EN selects forwarding, otherwise every EX/M RAW hazard stalls.
module hazard_fwd_ctrl
    import hazard_fwd_ctrl_pkg::*;
(
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          id_valid,
    input  logic [REG_ADDR_WIDTH-1:0]     id_rs1,
    input  logic [REG_ADDR_WIDTH-1:0]     id_rs2,
    input  logic                          id_rs1_used,
    input  logic                          id_rs2_used,
    input  logic [REG_ADDR_WIDTH-1:0]     id_rd,
    input  logic                          id_rd_we,
    input  logic                          id_is_load,
    input  logic                          flush,
    output logic [FORWARD_CTRL_WIDTH-1:0] forward_1,
    output logic [FORWARD_CTRL_WIDTH-1:0] forward_2,
    output logic                          stall,
    output logic                          bubble_ex
);

    shadow_t ex_q, ex_d;
    shadow_t m_q, m_d;
    shadow_t wb_q, wb_d;
    fwd_t    forward_1_q, forward_1_d;
    fwd_t    forward_2_q, forward_2_d;
    logic    bubble_ex_q, bubble_ex_d;

    fwd_t    code_1, code_2;
    logic    load_hit_1, load_hit_2;
    logic    raw_hit_1, raw_hit_2;
    logic    issue;
    logic    unused_ok;

    hazard_src_cmp u_src1 (
        .src      (id_rs1),
        .src_used (id_rs1_used),
        .ex_ent   (ex_q),
        .m_ent    (m_q),
        .fwd_code (code_1),
        .load_hit (load_hit_1),
        .raw_hit  (raw_hit_1)
    );

    hazard_src_cmp u_src2 (
        .src      (id_rs2),
        .src_used (id_rs2_used),
        .ex_ent   (ex_q),
        .m_ent    (m_q),
        .fwd_code (code_2),
        .load_hit (load_hit_2),
        .raw_hit  (raw_hit_2)
    );

    always_comb begin
`ifdef FORWARDING_EN
        stall = id_valid && !flush && (load_hit_1 || load_hit_2);
`else
        stall = id_valid && !flush && (raw_hit_1 || raw_hit_2);
`endif
        issue = id_valid && !stall && !flush;

        ex_d = '0;
        if (issue) begin
            ex_d = '{valid: 1'b1, rd: id_rd, we: id_rd_we, is_load: id_is_load};
        end
        m_d  = ex_q;
        wb_d = m_q;

        forward_1_d = FWD_NONE;
        forward_2_d = FWD_NONE;
`ifdef FORWARDING_EN
        if (issue) begin
            forward_1_d = code_1;
            forward_2_d = code_2;
        end
`endif
        bubble_ex_d = !issue;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q        <= '0;
            m_q         <= '0;
            wb_q        <= '0;
            forward_1_q <= FWD_NONE;
            forward_2_q <= FWD_NONE;
            bubble_ex_q <= 1'b1;
        end else begin
            ex_q        <= ex_d;
            m_q         <= m_d;
            wb_q        <= wb_d;
            forward_1_q <= forward_1_d;
            forward_2_q <= forward_2_d;
            bubble_ex_q <= bubble_ex_d;
        end
    end

    assign forward_1 = forward_1_q;
    assign forward_2 = forward_2_q;
    assign bubble_ex = bubble_ex_q;

    // WB is tracked for visibility only: the write-through regfile already covers ID reads.
`ifdef FORWARDING_EN
    assign unused_ok = &{1'b0, wb_q, raw_hit_1, raw_hit_2};
`else
    assign unused_ok = &{1'b0, wb_q, code_1, code_2, load_hit_1, load_hit_2};
`endif

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Directed-vector bench for hazard_fwd_ctrl; expectations follow whichever FORWARDING_EN build is compiled.
module tb_hazard_fwd_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       id_valid = 1'b0;
    logic [4:0] id_rs1 = '0;
    logic [4:0] id_rs2 = '0;
    logic       id_rs1_used = 1'b0;
    logic       id_rs2_used = 1'b0;
    logic [4:0] id_rd = '0;
    logic       id_rd_we = 1'b0;
    logic       id_is_load = 1'b0;
    logic       flush = 1'b0;
    logic [1:0] forward_1;
    logic [1:0] forward_2;
    logic       stall;
    logic       bubble_ex;

    hazard_fwd_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .id_valid    (id_valid),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_rs1_used (id_rs1_used),
        .id_rs2_used (id_rs2_used),
        .id_rd       (id_rd),
        .id_rd_we    (id_rd_we),
        .id_is_load  (id_is_load),
        .flush       (flush),
        .forward_1   (forward_1),
        .forward_2   (forward_2),
        .stall       (stall),
        .bubble_ex   (bubble_ex)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         step;
        logic       chk;
        logic       st;
        logic       bub;
        logic [1:0] f1;
        logic [1:0] f2;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   step_no = 0;

    task automatic cmp(input string name, input int step, input logic [1:0] act, input logic [1:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s step=%0d got=%b want=%b", name, step, act, req);
        end
    endtask

    // Monitor: the design presents a response every cycle; check it mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                if (e.chk) begin
                    cmp("stall",     e.step, {1'b0, stall},     {1'b0, e.st});
                    cmp("bubble_ex", e.step, {1'b0, bubble_ex}, {1'b0, e.bub});
                    cmp("forward_1", e.step, forward_1,         e.f1);
                    cmp("forward_2", e.step, forward_2,         e.f2);
                end
            end
        end
    end

    task automatic cyc(input logic r, input logic vld, input logic [4:0] s1, input logic [4:0] s2,
                       input logic u1, input logic u2, input logic [4:0] rd, input logic we,
                       input logic ld, input logic fl, input logic chk, input logic st,
                       input logic bub, input logic [1:0] f1, input logic [1:0] f2);
        exp_t e;
        #1;
        rst = r; id_valid = vld; id_rs1 = s1; id_rs2 = s2;
        id_rs1_used = u1; id_rs2_used = u2; id_rd = rd; id_rd_we = we;
        id_is_load = ld; flush = fl;
        e.step = step_no; e.chk = chk; e.st = st; e.bub = bub; e.f1 = f1; e.f2 = f2;
        exp_q.push_back(e);
        step_no++;
        @(posedge clk);
    endtask

    task automatic idle(input logic st, input logic bub, input logic [1:0] f1, input logic [1:0] f2);
        cyc(0, 0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 1, st, bub, f1, f2);
    endtask

    initial begin
        @(posedge clk);
        cyc(1, 0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00);
        idle(0, 1, 2'b00, 2'b00);

`ifdef FORWARDING_EN
        // addi x5 ; add x6,x5,x7 -> forward_1 = M
        cyc(0, 1, 5'd0, 5'd0, 1, 0, 5'd5, 1, 0, 0, 1, 0, 1, 2'b00, 2'b00);
        cyc(0, 1, 5'd5, 5'd7, 1, 1, 5'd6, 1, 0, 0, 1, 0, 0, 2'b00, 2'b00);
        idle(0, 0, 2'b10, 2'b00);
        idle(0, 1, 2'b00, 2'b00);
        // addi x5 ; nop ; sub x8,x0,x5 -> forward_2 = WB
        cyc(0, 1, 5'd0, 5'd0, 1, 0, 5'd5, 1, 0, 0, 1, 0, 1, 2'b00, 2'b00);
        idle(0, 0, 2'b00, 2'b00);
        cyc(0, 1, 5'd0, 5'd5, 1, 1, 5'd8, 1, 0, 0, 1, 0, 1, 2'b00, 2'b00);
        idle(0, 0, 2'b00, 2'b01);
        idle(0, 1, 2'b00, 2'b00);
        // lw x3 ; add x4,x3,x3 -> one stall, bubble, then both WB
        cyc(0, 1, 5'd2, 5'd0, 1, 0, 5'd3, 1, 1, 0, 1, 0, 1, 2'b00, 2'b00);
        cyc(0, 1, 5'd3, 5'd3, 1, 1, 5'd4, 1, 0, 0, 1, 1, 0, 2'b00, 2'b00);
        cyc(0, 1, 5'd3, 5'd3, 1, 1, 5'd4, 1, 0, 0, 1, 0, 1, 2'b00, 2'b00);
        idle(0, 0, 2'b01, 2'b01);
        idle(0, 1, 2'b00, 2'b00);
        // lw x10 ; lw x11,0(x10) ; add x12,x11,x0 -> independent stalls
        cyc(0, 1, 5'd2,  5'd0, 1, 0, 5'd10, 1, 1, 0, 1, 0, 1, 2'b00, 2'b00);
        cyc(0, 1, 5'd10, 5'd0, 1, 0, 5'd11, 1, 1, 0, 1, 1, 0, 2'b00, 2'b00);
        cyc(0, 1, 5'd10, 5'd0, 1, 0, 5'd11, 1, 1, 0, 1, 0, 1, 2'b00, 2'b00);
        cyc(0, 1, 5'd11, 5'd0, 1, 1, 5'd12, 1, 0, 0, 1, 1, 0, 2'b01, 2'b00);
        cyc(0, 1, 5'd11, 5'd0, 1, 1, 5'd12, 1, 0, 0, 1, 0, 1, 2'b00, 2'b00);
        idle(0, 0, 2'b01, 2'b00);
        idle(0, 1, 2'b00, 2'b00);
`else
        // addi x5 ; add x6,x5,x7 -> two stall cycles, codes stay NONE
        cyc(0, 1, 5'd0, 5'd0, 1, 0, 5'd5, 1, 0, 0, 1, 0, 1, 2'b00, 2'b00);
        cyc(0, 1, 5'd5, 5'd7, 1, 1, 5'd6, 1, 0, 0, 1, 1, 0, 2'b00, 2'b00);
        cyc(0, 1, 5'd5, 5'd7, 1, 1, 5'd6, 1, 0, 0, 1, 1, 1, 2'b00, 2'b00);
        cyc(0, 1, 5'd5, 5'd7, 1, 1, 5'd6, 1, 0, 0, 1, 0, 1, 2'b00, 2'b00);
        idle(0, 0, 2'b00, 2'b00);
        idle(0, 1, 2'b00, 2'b00);
        // addi x5 ; nop ; sub x8,x0,x5 -> one stall cycle
        cyc(0, 1, 5'd0, 5'd0, 1, 0, 5'd5, 1, 0, 0, 1, 0, 1, 2'b00, 2'b00);
        idle(0, 0, 2'b00, 2'b00);
        cyc(0, 1, 5'd0, 5'd5, 1, 1, 5'd8, 1, 0, 0, 1, 1, 1, 2'b00, 2'b00);
        cyc(0, 1, 5'd0, 5'd5, 1, 1, 5'd8, 1, 0, 0, 1, 0, 1, 2'b00, 2'b00);
        idle(0, 0, 2'b00, 2'b00);
        idle(0, 1, 2'b00, 2'b00);
        // lw x3 ; add x4,x3,x3 -> two stall cycles without forwarding
        cyc(0, 1, 5'd2, 5'd0, 1, 0, 5'd3, 1, 1, 0, 1, 0, 1, 2'b00, 2'b00);
        cyc(0, 1, 5'd3, 5'd3, 1, 1, 5'd4, 1, 0, 0, 1, 1, 0, 2'b00, 2'b00);
        cyc(0, 1, 5'd3, 5'd3, 1, 1, 5'd4, 1, 0, 0, 1, 1, 1, 2'b00, 2'b00);
        cyc(0, 1, 5'd3, 5'd3, 1, 1, 5'd4, 1, 0, 0, 1, 0, 1, 2'b00, 2'b00);
        idle(0, 0, 2'b00, 2'b00);
        idle(0, 1, 2'b00, 2'b00);
`endif
        // addi x0 ; add x1,x0,x0 -> x0 never matches
        cyc(0, 1, 5'd0, 5'd0, 1, 0, 5'd0, 1, 0, 0, 1, 0, 1, 2'b00, 2'b00);
        cyc(0, 1, 5'd0, 5'd0, 1, 1, 5'd1, 1, 0, 0, 1, 0, 0, 2'b00, 2'b00);
        idle(0, 0, 2'b00, 2'b00);
        idle(0, 1, 2'b00, 2'b00);
        // lw x3 ; dependent add killed by flush -> no stall, bubble next
        cyc(0, 1, 5'd2, 5'd0, 1, 0, 5'd3, 1, 1, 0, 1, 0, 1, 2'b00, 2'b00);
        cyc(0, 1, 5'd3, 5'd3, 1, 1, 5'd4, 1, 0, 1, 1, 0, 0, 2'b00, 2'b00);
        idle(0, 1, 2'b00, 2'b00);
        idle(0, 1, 2'b00, 2'b00);
        idle(0, 1, 2'b00, 2'b00);
        // reset during a stall clears the shadow pipeline
        cyc(0, 1, 5'd2, 5'd0, 1, 0, 5'd3, 1, 1, 0, 1, 0, 1, 2'b00, 2'b00);
        cyc(1, 1, 5'd3, 5'd3, 1, 1, 5'd4, 1, 0, 0, 1, 1, 0, 2'b00, 2'b00);
        cyc(0, 1, 5'd3, 5'd3, 1, 1, 5'd4, 1, 0, 0, 1, 0, 1, 2'b00, 2'b00);
        idle(0, 0, 2'b00, 2'b00);
        idle(0, 1, 2'b00, 2'b00);

        repeat (2) @(posedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain left=%0d want=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
